// File: rtl/j1p_pkg.sv
// Purpose: shared J1 ISA field positions, ALU opcodes, core state and fault encodings.
// Latency: n/a (constants, types and one decode helper only).
// Backpressure: n/a.
package j1p_pkg;

  // Instruction word layout (32-bit J1 encoding)
  localparam int LIT_BIT = 31;  // 1 = literal, [30:0] immediate
  localparam int TYPE_HI = 30;
  localparam int TYPE_LO = 29;
  localparam int SPC_HI  = 14;  // ALU special field
  localparam int SPC_LO  = 13;
  localparam int RPC_BIT = 12;  // R -> PC
  localparam int OP_HI   = 11;
  localparam int OP_LO   = 8;
  localparam int TN_BIT  = 7;   // T -> N
  localparam int TR_BIT  = 6;   // T -> R
  localparam int NT_BIT  = 5;   // N -> [T]
  localparam int RD_HI   = 3;
  localparam int RD_LO   = 2;
  localparam int DD_HI   = 1;
  localparam int DD_LO   = 0;

  // Data addresses whose T[15:12] nibble matches this go to the UART, not Wishbone
  localparam int         UART_HI       = 15;
  localparam int         UART_LO       = 12;
  localparam logic [3:0] UART_APERTURE = 4'hF;

  typedef enum logic [1:0] {TY_JMP, TY_CJMP, TY_CALL, TY_ALU} insn_type_e;

  typedef enum logic [3:0] {
    OP_T, OP_N, OP_ADD, OP_AND, OP_OR, OP_XOR, OP_INV, OP_EQ,
    OP_LT, OP_RSH, OP_DEC, OP_R, OP_LOAD, OP_LSH, OP_DEPTH, OP_ULT
  } alu_op_e;

  typedef enum logic [1:0] {SPC_NONE, SPC_STATE, SPC_START, SPC_RSVD} special_e;

  typedef enum logic [2:0] {ST_HALT, ST_FETCH, ST_EXEC, ST_MEM, ST_FAULT} state_e;

  typedef enum logic [1:0] {FLT_NONE, FLT_D_OVF, FLT_D_UNF, FLT_R} fault_e;

  // Stack delta plus "move" bit to {push, pop}. A move with zero delta
  // overwrites the top entry, expressed as a simultaneous push and pop.
  function automatic logic [1:0] stack_ops(input logic [1:0] delta, input logic move);
    stack_ops = {(delta == 2'b01) || (move && delta == 2'b00),
                 (delta == 2'b11) || (move && delta == 2'b00)};
  endfunction

endpackage

// File: rtl/j1p_stack.sv
// Purpose: LIFO with occupancy counter and overflow/underflow flags (ports:
//   clear/commit/push/pop/wdat in; top/cnt/ovf/unf out).
// Latency: top_o is combinational; writes and count update on the commit edge.
// Backpressure: none; caller must not commit when ovf_o/unf_o are set.
module j1p_stack
  import j1p_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     commit_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdat_i,
  output logic [WIDTH-1:0]         top_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     ovf_o,
  output logic                     unf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    top_idx, wr_idx;

  // Low bits wrap, so top of an empty or full stack indexes DEPTH-1.
  assign top_idx = cnt_q[AW-1:0] - AW'(1);
  assign wr_idx  = (push_i && pop_i) ? top_idx : cnt_q[AW-1:0];
  assign top_o   = mem_q[top_idx];
  assign cnt_o   = cnt_q;
  assign ovf_o   = push_i && !pop_i && (cnt_q == CW'(DEPTH));
  assign unf_o   = pop_i && !push_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (commit_i) begin
      if (push_i && !pop_i) cnt_d = cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (commit_i && push_i) mem_q[wr_idx] <= wdat_i;
  end

endmodule

// File: rtl/wb_j1p_cpu_master.sv
// Purpose: multicycle J1 core; ports: instruction fetch (inst_*), Wishbone
//   classic data master, UART aperture strobes, cluster start/status, fault.
// Latency: CPI 2 on zero-wait fetch, 3 + wait states for a Wishbone access;
//   fetch/data requests held stable until their ack (stray acks ignored).
module wb_j1p_cpu_master
  import j1p_pkg::*;
#(
  parameter int CORE_ID      = 0,
  parameter int N_CORES      = 4,
  parameter int PC_W         = 14,
  parameter int ADR_W        = 16,
  parameter int DSTACK_DEPTH = 32,
  parameter int RSTACK_DEPTH = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  output logic                                      inst_cyc_o,
  output logic [PC_W-1:0]                           inst_adr_o,
  input  logic [31:0]                               inst_i,
  input  logic                                      inst_ack_i,
  output logic                                      cyc_o,
  output logic                                      stb_o,
  output logic                                      we_o,
  output logic [ADR_W-1:0]                          adr_o,
  output logic [31:0]                               dat_o,
  input  logic [31:0]                               dat_i,
  input  logic                                      ack_i,
  output logic                                      uart_rd_o,
  output logic                                      uart_wr_o,
  output logic                                      uart_adr_o,
  output logic [7:0]                                uart_dat_o,
  input  logic [7:0]                                uart_dat_i,
  input  logic [N_CORES-1:0]                        core_state_i,
  input  logic                                      start_i,
  input  logic [PC_W-1:0]                           start_adr_i,
  output logic                                      start_req_o,
  output logic [(N_CORES>1?$clog2(N_CORES):1)-1:0]  start_num_o,
  output logic [PC_W-1:0]                           start_pc_o,
  output logic                                      halted_o,
  output logic                                      fault_o,
  output logic [1:0]                                fault_code_o
);
  localparam int NUM_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int DCW   = $clog2(DSTACK_DEPTH) + 1;
  localparam int RCW   = $clog2(RSTACK_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       t_q, t_d, insn_q, insn_d;
  fault_e            fault_code_q, fault_code_d;
  logic              inst_cyc_q, inst_cyc_d, cyc_q, cyc_d, we_q, we_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;

  logic [31:0]       n_top, r_top, alu, t_next, r_wdat;
  logic [DCW-1:0]    d_cnt;
  logic [RCW-1:0]    r_cnt;
  logic              d_push, d_pop, r_push, r_pop, d_commit, r_commit, stk_clear;
  logic              d_ovf, d_unf, r_ovf, r_unf, fault_any;
  logic [PC_W-1:0]   pc_inc, pc_next;
  logic              uart_rd, uart_wr, start_req;

  // Decode
  insn_type_e ityp;
  alu_op_e    op;
  special_e   spc;
  logic       is_lit, is_alu, is_load, is_store, is_uart, wb_access;

  assign is_lit    = insn_q[LIT_BIT];
  assign ityp      = insn_type_e'(insn_q[TYPE_HI:TYPE_LO]);
  assign op        = alu_op_e'(insn_q[OP_HI:OP_LO]);
  assign spc       = special_e'(insn_q[SPC_HI:SPC_LO]);
  assign is_alu    = !is_lit && (ityp == TY_ALU);
  assign is_load   = is_alu && (op == OP_LOAD);
  assign is_store  = is_alu && insn_q[NT_BIT];
  assign is_uart   = (t_q[UART_HI:UART_LO] == UART_APERTURE);
  assign wb_access = (is_load || is_store) && !is_uart;
  assign pc_inc    = pc_q + PC_W'(1);

  always_comb begin
    alu = t_q;
    case (op)
      OP_N:     alu = n_top;
      OP_ADD:   alu = t_q + n_top;
      OP_AND:   alu = t_q & n_top;
      OP_OR:    alu = t_q | n_top;
      OP_XOR:   alu = t_q ^ n_top;
      OP_INV:   alu = ~t_q;
      OP_EQ:    alu = {32{n_top == t_q}};
      OP_LT:    alu = {32{$signed(n_top) < $signed(t_q)}};
      OP_RSH:   alu = n_top >> t_q[4:0];
      OP_DEC:   alu = t_q - 32'd1;
      OP_R:     alu = r_top;
      OP_LOAD:  alu = is_uart ? {24'b0, uart_dat_i} : dat_i;
      OP_LSH:   alu = n_top << t_q[4:0];
      OP_DEPTH: alu = 32'({r_cnt, d_cnt});
      OP_ULT:   alu = {32{n_top < t_q}};
      default:  alu = t_q;
    endcase
    if (spc == SPC_STATE) alu = 32'(core_state_i);
  end

  // Next architectural values for the latched instruction (not yet committed)
  always_comb begin
    d_push  = 1'b0;
    d_pop   = 1'b0;
    r_push  = 1'b0;
    r_pop   = 1'b0;
    r_wdat  = 32'(pc_inc);
    t_next  = t_q;
    pc_next = pc_inc;
    if (is_lit) begin
      d_push = 1'b1;
      t_next = {1'b0, insn_q[30:0]};
    end else begin
      case (ityp)
        TY_JMP:  pc_next = insn_q[PC_W-1:0];
        TY_CJMP: begin
          d_pop  = 1'b1;
          t_next = n_top;
          if (t_q == '0) pc_next = insn_q[PC_W-1:0];
        end
        TY_CALL: begin
          r_push  = 1'b1;
          pc_next = insn_q[PC_W-1:0];
        end
        default: begin
          {d_push, d_pop} = stack_ops(insn_q[DD_HI:DD_LO], insn_q[TN_BIT]);
          {r_push, r_pop} = stack_ops(insn_q[RD_HI:RD_LO], insn_q[TR_BIT]);
          r_wdat = t_q;
          t_next = alu;
          if (insn_q[RPC_BIT]) pc_next = r_top[PC_W-1:0];
        end
      endcase
    end
  end

  assign fault_any = d_ovf || d_unf || r_ovf || r_unf;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    t_d          = t_q;
    insn_d       = insn_q;
    fault_code_d = fault_code_q;
    d_commit     = 1'b0;
    r_commit     = 1'b0;
    stk_clear    = 1'b0;
    cyc_d        = 1'b0;
    we_d         = 1'b0;
    adr_d        = '0;
    dat_d        = '0;
    uart_rd      = 1'b0;
    uart_wr      = 1'b0;
    start_req    = 1'b0;
    case (state_q)
      ST_HALT, ST_FAULT: begin
        if (start_i) begin
          state_d      = ST_FETCH;
          pc_d         = start_adr_i;
          t_d          = '0;
          fault_code_d = FLT_NONE;
          stk_clear    = 1'b1;
        end
      end
      ST_FETCH: begin
        if (inst_cyc_q && inst_ack_i) begin
          insn_d  = inst_i;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (fault_any) begin
          state_d = ST_FAULT;
          if (d_ovf)      fault_code_d = FLT_D_OVF;
          else if (d_unf) fault_code_d = FLT_D_UNF;
          else            fault_code_d = FLT_R;
        end else if (wb_access) begin
          state_d = ST_MEM;
          cyc_d   = 1'b1;
          we_d    = is_store;
          adr_d   = t_q[ADR_W-1:0];
          dat_d   = n_top;
        end else begin
          state_d   = ST_FETCH;
          pc_d      = pc_next;
          t_d       = t_next;
          d_commit  = 1'b1;
          r_commit  = 1'b1;
          uart_rd   = is_load && is_uart;
          uart_wr   = is_store && is_uart;
          start_req = is_alu && (spc == SPC_START);
        end
      end
      ST_MEM: begin
        if (ack_i) begin
          state_d  = ST_FETCH;
          pc_d     = pc_next;
          t_d      = t_next;
          d_commit = 1'b1;
          r_commit = 1'b1;
        end else begin
          cyc_d = 1'b1;
          we_d  = we_q;
          adr_d = adr_q;
          dat_d = dat_q;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign inst_cyc_d = (state_d == ST_FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= (CORE_ID == 0) ? ST_FETCH : ST_HALT;
      pc_q         <= '0;
      t_q          <= '0;
      insn_q       <= '0;
      fault_code_q <= FLT_NONE;
      inst_cyc_q   <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      t_q          <= t_d;
      insn_q       <= insn_d;
      fault_code_q <= fault_code_d;
      inst_cyc_q   <= inst_cyc_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
    end
  end

  j1p_stack #(.DEPTH(DSTACK_DEPTH), .WIDTH(32)) u_dstack (
    .clk(clk), .rst(rst), .clear_i(stk_clear), .commit_i(d_commit),
    .push_i(d_push), .pop_i(d_pop), .wdat_i(t_q),
    .top_o(n_top), .cnt_o(d_cnt), .ovf_o(d_ovf), .unf_o(d_unf)
  );

  j1p_stack #(.DEPTH(RSTACK_DEPTH), .WIDTH(32)) u_rstack (
    .clk(clk), .rst(rst), .clear_i(stk_clear), .commit_i(r_commit),
    .push_i(r_push), .pop_i(r_pop), .wdat_i(r_wdat),
    .top_o(r_top), .cnt_o(r_cnt), .ovf_o(r_ovf), .unf_o(r_unf)
  );

  assign inst_cyc_o   = inst_cyc_q;
  assign inst_adr_o   = pc_q;
  assign cyc_o        = cyc_q;
  assign stb_o        = cyc_q;
  assign we_o         = we_q;
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;
  assign uart_rd_o    = uart_rd;
  assign uart_wr_o    = uart_wr;
  assign uart_adr_o   = (uart_rd || uart_wr) ? t_q[0] : 1'b0;
  assign uart_dat_o   = uart_wr ? n_top[7:0] : 8'h00;
  assign start_req_o  = start_req;
  assign start_num_o  = start_req ? t_q[NUM_W-1:0] : '0;
  assign start_pc_o   = start_req ? n_top[PC_W-1:0] : '0;
  assign halted_o     = (state_q == ST_HALT) || (state_q == ST_FAULT);
  assign fault_o      = (state_q == ST_FAULT);
  assign fault_code_o = fault_code_q;

endmodule

// File: tb/tb_wb_j1p_cpu_master.sv
// Purpose: self-checking bench for wb_j1p_cpu_master (core 0 program run, core 1 start).
// Latency: zero-wait fetch model, Wishbone slave acks after 3 wait states.
// Backpressure: slave inserts waits on every data access.
module tb_wb_j1p_cpu_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // core 0
  logic        inst_cyc0, inst_ack0, cyc0, stb0, we0, ack0;
  logic [13:0] inst_adr0, start_adr0, start_pc0;
  logic [31:0] inst_dat0, dato0, dati0;
  logic [15:0] adr0;
  logic        uart_rd0, uart_wr0, uart_adr0, start0, start_req0, halted0, fault0;
  logic [7:0]  uart_dato0, uart_dati0;
  logic [1:0]  start_num0, fcode0;
  // core 1
  logic        inst_cyc1, cyc1, stb1, we1, uart_rd1, uart_wr1, uart_adr1;
  logic [13:0] inst_adr1, start_adr1, start_pc1;
  logic [31:0] dato1;
  logic [15:0] adr1;
  logic [7:0]  uart_dato1;
  logic        start1, start_req1, halted1, fault1;
  logic [1:0]  start_num1, fcode1;
  logic [3:0]  core_state;

  wb_j1p_cpu_master #(.CORE_ID(0)) dut0 (
    .clk(clk), .rst(rst), .inst_cyc_o(inst_cyc0), .inst_adr_o(inst_adr0), .inst_i(inst_dat0),
    .inst_ack_i(inst_ack0), .cyc_o(cyc0), .stb_o(stb0), .we_o(we0), .adr_o(adr0), .dat_o(dato0),
    .dat_i(dati0), .ack_i(ack0), .uart_rd_o(uart_rd0), .uart_wr_o(uart_wr0), .uart_adr_o(uart_adr0),
    .uart_dat_o(uart_dato0), .uart_dat_i(uart_dati0), .core_state_i(core_state), .start_i(start0),
    .start_adr_i(start_adr0), .start_req_o(start_req0), .start_num_o(start_num0), .start_pc_o(start_pc0),
    .halted_o(halted0), .fault_o(fault0), .fault_code_o(fcode0));

  wb_j1p_cpu_master #(.CORE_ID(1)) dut1 (
    .clk(clk), .rst(rst), .inst_cyc_o(inst_cyc1), .inst_adr_o(inst_adr1), .inst_i(32'h0),
    .inst_ack_i(1'b0), .cyc_o(cyc1), .stb_o(stb1), .we_o(we1), .adr_o(adr1), .dat_o(dato1),
    .dat_i(32'h0), .ack_i(1'b0), .uart_rd_o(uart_rd1), .uart_wr_o(uart_wr1), .uart_adr_o(uart_adr1),
    .uart_dat_o(uart_dato1), .uart_dat_i(8'h00), .core_state_i(core_state), .start_i(start1),
    .start_adr_i(start_adr1), .start_req_o(start_req1), .start_num_o(start_num1), .start_pc_o(start_pc1),
    .halted_o(halted1), .fault_o(fault1), .fault_code_o(fcode1));

  // Instruction memory and bus models
  logic [31:0] imem [512];
  logic [1:0]  ws;
  assign inst_dat0  = imem[inst_adr0[8:0]];
  assign inst_ack0  = inst_cyc0;
  assign ack0       = cyc0 && stb0 && (ws == 2'd3);
  assign dati0      = 32'hCAFE0000 | 32'(adr0);
  assign uart_dati0 = 8'hA5;
  assign core_state = 4'b0001;
  always @(posedge clk) ws <= (cyc0 && stb0 && !ack0) ? ws + 2'd1 : 2'd0;

  function automatic logic [31:0] f_lit(input int v);
    return {1'b1, 31'(v)};
  endfunction
  function automatic logic [31:0] f_br(input logic [1:0] ty, input int a);
    return {1'b0, ty, 29'(a)};
  endfunction
  function automatic logic [31:0] f_alu(input logic [1:0] spc, input logic rpc, input logic [3:0] op,
                                        input logic nt, input logic [1:0] rd, input logic [1:0] dd);
    return {3'b011, 14'b0, spc, rpc, op, 1'b0, 1'b0, nt, 1'b0, rd, dd};
  endfunction

  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard
  typedef struct packed {logic we; logic [15:0] adr; logic [31:0] dat;} wb_t;
  wb_t         exp_wb[$];
  logic [13:0] exp_fetch[$];
  logic [15:0] exp_start[$];
  logic        exp_uart[$];

  int cyc_n = 0, t_f0 = -1, t_f3 = -1, wb_len = 0;
  logic uart_prev = 1'b0, start_prev = 1'b0, saw_fetch1 = 1'b0;
  logic [13:0] e_pc;
  wb_t e_wb;
  logic [15:0] e_st;

  always @(negedge clk) begin
    if (!rst) begin
      cyc_n++;
      if (inst_cyc1) saw_fetch1 = 1'b1;
      if (inst_cyc0 && inst_ack0) begin
        if (exp_fetch.size() == 0) check("fetch_unexp", 32'(inst_adr0), 32'hFFFFFFFF);
        else begin
          e_pc = exp_fetch.pop_front();
          check("fetch_pc", 32'(inst_adr0), 32'(e_pc));
          if (e_pc == 14'd0 && t_f0 < 0) t_f0 = cyc_n;
          if (e_pc == 14'd3 && t_f3 < 0) t_f3 = cyc_n;
        end
      end
      if (cyc0) begin
        wb_len++;
        if (ack0) begin
          check("wb_stb", 32'(stb0), 32'd1);
          if (exp_wb.size() == 0) check("wb_unexp", 32'(adr0), 32'hFFFFFFFF);
          else begin
            e_wb = exp_wb.pop_front();
            check("wb_we", 32'(we0), 32'(e_wb.we));
            check("wb_adr", 32'(adr0), 32'(e_wb.adr));
            if (e_wb.we) check("wb_dat", dato0, e_wb.dat);
          end
          check("wb_len", 32'(wb_len), 32'd4);
          wb_len = 0;
        end
      end
      if (uart_rd0) begin
        check("uart_rd_pulse", 32'(uart_prev), 32'd0);
        if (exp_uart.size() == 0) check("uart_unexp", 32'(uart_adr0), 32'hFFFFFFFF);
        else check("uart_adr", 32'(uart_adr0), 32'(exp_uart.pop_front()));
      end
      if (uart_wr0) check("uart_wr_unexp", 32'(uart_wr0), 32'd0);
      if (start_req0) begin
        check("start_pulse", 32'(start_prev), 32'd0);
        if (exp_start.size() == 0) check("start_unexp", 32'(start_pc0), 32'hFFFFFFFF);
        else begin
          e_st = exp_start.pop_front();
          check("start_num", 32'(start_num0), 32'(e_st[15:14]));
          check("start_pc", 32'(start_pc0), 32'(e_st[13:0]));
        end
      end
      uart_prev  = uart_rd0;
      start_prev = start_req0;
    end
  end

  task automatic wait_fault(input string tag);
    int n = 0;
    while (!fault0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(fault0), 32'd1);
  endtask

  task automatic wait_sig(input logic which);
    int n = 0;
    while (((which == 1'b0) ? !cyc0 : !inst_cyc0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_bus", 32'(n < 500), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) imem[i] = f_alu(2'd0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0);
    imem[0]  = f_lit(5);
    imem[1]  = f_lit(3);
    imem[2]  = f_alu(2'd0, 1'b0, 4'd2, 1'b0, 2'd0, 2'd3);   // add, drop
    imem[3]  = f_lit('h40);
    imem[4]  = f_alu(2'd0, 1'b0, 4'd1, 1'b1, 2'd0, 2'd3);   // store
    imem[5]  = f_lit('hF001);
    imem[6]  = f_alu(2'd0, 1'b0, 4'd12, 1'b0, 2'd0, 2'd0);  // load (UART)
    imem[7]  = f_lit('h44);
    imem[8]  = f_alu(2'd0, 1'b0, 4'd1, 1'b1, 2'd0, 2'd3);
    imem[9]  = f_lit('h80);
    imem[10] = f_alu(2'd0, 1'b0, 4'd12, 1'b0, 2'd0, 2'd0);  // load (Wishbone)
    imem[11] = f_lit('h48);
    imem[12] = f_alu(2'd0, 1'b0, 4'd1, 1'b1, 2'd0, 2'd3);
    imem[13] = f_lit('h300);
    imem[14] = f_lit(2);
    imem[15] = f_alu(2'd2, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0);   // start core
    imem[16] = f_lit(0);
    imem[17] = f_br(2'd1, 19);
    imem[18] = f_lit('hBAD);
    imem[19] = f_br(2'd2, 40);
    imem[20] = f_br(2'd0, 50);
    imem[40] = f_alu(2'd0, 1'b1, 4'd0, 1'b0, 2'd3, 2'd0);   // return
    for (int i = 50; i < 55; i++) imem[i] = f_alu(2'd0, 1'b0, 4'd1, 1'b0, 2'd0, 2'd3);
    for (int i = 55; i < 88; i++) imem[i] = f_lit(i);
    imem[256] = f_alu(2'd0, 1'b0, 4'd1, 1'b0, 2'd0, 2'd3);  // drop on empty
    imem[272] = f_alu(2'd0, 1'b1, 4'd0, 1'b0, 2'd3, 2'd0);  // return on empty

    for (int i = 0; i < 18; i++) exp_fetch.push_back(14'(i));
    exp_fetch.push_back(14'd19);
    exp_fetch.push_back(14'd40);
    exp_fetch.push_back(14'd20);
    for (int i = 50; i < 88; i++) exp_fetch.push_back(14'(i));
    exp_wb.push_back('{1'b1, 16'h0040, 32'h8});
    exp_wb.push_back('{1'b1, 16'h0044, 32'hA5});
    exp_wb.push_back('{1'b0, 16'h0080, 32'h0});
    exp_wb.push_back('{1'b1, 16'h0048, 32'hCAFE0080});
    exp_uart.push_back(1'b1);
    exp_start.push_back({2'd2, 14'h300});

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start_adr0 = '0; start_adr1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_inst_cyc0", 32'(inst_cyc0), 32'd0);
    check("rst_cyc0", 32'(cyc0), 32'd0);
    check("rst_halted0", 32'(halted0), 32'd0);
    check("rst_fault0", 32'(fault0), 32'd0);
    check("rst_fcode0", 32'(fcode0), 32'd0);
    check("rst_halted1", 32'(halted1), 32'd1);
    check("rst_start_req0", 32'(start_req0), 32'd0);
    rst = 1'b0;

    // start pulses while core 0 is in MEM and then FETCH must be ignored
    wait_sig(1'b0);
    start0 = 1'b1; start_adr0 = 14'h1FF;
    @(negedge clk);
    start0 = 1'b0;
    wait_sig(1'b1);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;

    wait_fault("ovf_fault");
    check("cpi_lit_lit_add", 32'(t_f3 - t_f0), 32'd6);
    check("ovf_code", 32'(fcode0), 32'd1);
    check("ovf_pc", 32'(inst_adr0), 32'd87);
    check("ovf_halted", 32'(halted0), 32'd1);
    check("ovf_no_fetch", 32'(inst_cyc0), 32'd0);
    check("fetch_left", 32'(exp_fetch.size()), 32'd0);
    check("wb_left", 32'(exp_wb.size()), 32'd0);
    check("uart_left", 32'(exp_uart.size()), 32'd0);
    check("start_left", 32'(exp_start.size()), 32'd0);

    exp_fetch.push_back(14'h100);
    start0 = 1'b1; start_adr0 = 14'h100;
    @(negedge clk);
    start0 = 1'b0;
    check("restart_adr", 32'(inst_adr0), 32'h100);
    check("restart_fault_clr", 32'(fault0), 32'd0);
    check("restart_code_clr", 32'(fcode0), 32'd0);
    wait_fault("unf_fault");
    check("unf_code", 32'(fcode0), 32'd2);
    check("unf_pc", 32'(inst_adr0), 32'h100);

    exp_fetch.push_back(14'h110);
    start0 = 1'b1; start_adr0 = 14'h110;
    @(negedge clk);
    start0 = 1'b0;
    wait_fault("r_fault");
    check("r_code", 32'(fcode0), 32'd3);
    check("fetch_left2", 32'(exp_fetch.size()), 32'd0);

    // core 1: halted until started
    check("c1_no_fetch", 32'(saw_fetch1), 32'd0);
    check("c1_halted", 32'(halted1), 32'd1);
    start1 = 1'b1; start_adr1 = 14'h20;
    @(negedge clk);
    start1 = 1'b0;
    check("c1_adr", 32'(inst_adr1), 32'h20);
    check("c1_cyc", 32'(inst_cyc1), 32'd1);
    check("c1_running", 32'(halted1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
